ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 64 KB main RAM between three requesters: CPU, HPS download writes, and the tape/cartridge reader.
- CPU accesses are timed to the CPU clock enable and always win. Download writes go into a small FIFO and drain in idle cycles. The reader uses a req/ack handshake.
- Sits between T80/PLA and the main RAM instance, replacing the direct dual-port arrangement.

Parameters:
- DEPTH, 4, download write FIFO entries (power of 2, ≥2).
- AW, 16, RAM address width.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_ce  in  1  CPU clock enable (ce_3m5)
- cpu_sel  in  1  CPU memory cycle targets RAM (qualified RD/WR strobe)
- cpu_we  in  1  CPU write
- cpu_addr  in  AW  CPU address
- cpu_din  in  8  CPU write data
- cpu_q  out  8  CPU read data
- dl_active  in  1  download in progress (ioctl_download & index match)
- dl_wr  in  1  one-cycle download write strobe
- dl_addr  in  AW  download target address (already offset by caller)
- dl_data  in  8  download byte
- dl_busy  out  1  download active or FIFO non-empty
- dl_done  out  1  one-cycle pulse when load finished
- dl_ovf  out  1  sticky: download write dropped
- rd_req  in  1  reader request, held until ack
- rd_addr  in  AW  reader address, stable while rd_req
- rd_ack  out  1  one-cycle pulse, rd_q valid
- rd_q  out  8  reader data
- mem_addr  out  AW  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_din  out  8  RAM write data (combinational)
- mem_dout  in  8  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset: FIFO empty, rd in-flight cleared, last_bg=0.
- Reset values of registered outputs: cpu_q=0, rd_q=0, rd_ack=0, dl_done=0, dl_ovf=0.
- After reset: mem_we=0, mem_addr=0, mem_din=0 while no grant.
- A rd_req pending at reset is discarded. The reader must hold or re-raise rd_req.
- Slot decision each cycle G, in priority order:
  - 1. CPU if cpu_ce & cpu_sel.
  - 2. Background: FIFO non-empty (F) and rd eligible (T, meaning rd_req & !inflight).
    - Both pending: grant the one not served last (last_bg toggles per background grant; 0 = FIFO served last).
    - Only one pending: grant it.
  - 3. Idle: mem_we=0, mem_addr holds its last value.
- CPU grant: mem_addr=cpu_addr, mem_we=cpu_we, mem_din=cpu_din.
  - On a read, cpu_q is loaded from mem_dout at the end of G+1 and is visible from G+2 until the next CPU read.
- FIFO grant: pop the head; mem_we=1 with the head's addr/data.
- Reader grant: mem_addr=rd_addr, inflight=1.
  - G+1: mem_dout registered into rd_q.
  - G+2: rd_ack=1 and inflight cleared.
  - Reader is ineligible while inflight, so it is never double-served. The requester drops rd_req in the ack cycle.
- Latency with no contention:
  - Reader: ack 2 cycles after grant.
  - Download write: reaches RAM 1 cycle after dl_wr (FIFO registered).
- FIFO push on dl_wr:
  - Full with no pop in the same cycle: byte dropped, dl_ovf=1 (cleared only by reset).
  - Full with a pop in the same cycle: push accepted, count unchanged.
  - Empty: a byte pushed in cycle N is poppable in N+1, never in N.
- CPU starvation: if cpu_ce & cpu_sel is held every cycle, background requesters wait. No data is lost; FIFO overflow rules apply.
- dl_busy = dl_active | (count != 0).
- dl_done pulses one cycle when dl_busy falls 1→0.
- Address/count wrap: FIFO pointers are modulo DEPTH; count is width log2(DEPTH)+1.

Test Plan:
- Reset, then idle → all registered outputs 0, mem_we=0, dl_busy=0.
- CPU write 0xA5 to 0x3900 on cpu_ce, then CPU read of 0x3900 → mem_we=1 in the write cycle; cpu_q=0xA5 two cycles after the read grant.
- 5 back-to-back dl_wr with DEPTH=4 and cpu_ce&cpu_sel held every cycle:
  - first 4 bytes buffered, 5th dropped, dl_ovf=1;
  - once CPU releases, 4 writes drain in order;
  - dl_done pulses exactly once after dl_active falls and the FIFO empties.
- rd_req to 0x0123 (RAM=0x5C) with FIFO empty, no CPU → rd_ack exactly 2 cycles after grant, rd_q=0x5C; no second ack while rd_req stays high through the ack cycle.
- FIFO non-empty and rd_req both pending with no CPU slots → grants alternate FIFO/reader/FIFO by last_bg; a cpu_ce&cpu_sel cycle inserted mid-sequence is granted to the CPU without disturbing the alternation order.
- Reset asserted during a reader in-flight and with 3 FIFO entries → no rd_ack, FIFO empty, dl_ovf=0 the following cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// Single-port main RAM arbiter: CPU, download-write FIFO, and tape/cart reader.
// The CPU always wins its enabled slot. The FIFO and the reader share the
// remaining cycles, and the one not served last goes first. RAM read data
// arrives one cycle after the address is presented.
module ram_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 16
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          cpu_ce,
   input  logic          cpu_sel,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_q,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_busy,
   output logic          dl_done,
   output logic          dl_ovf,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ack,
   output logic [7:0]    rd_q,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [7:0]    mem_din,
   input  logic [7:0]    mem_dout
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] fifo_addr_q [DEPTH];
   logic [7:0]    fifo_data_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic          rd_pend_q, rd_pend_d;
   logic          cpu_pend_q, cpu_pend_d;
   logic          last_bg_q, last_bg_d;
   logic          busy_q, busy_d;
   logic          rd_ack_q, rd_ack_d;
   logic          dl_done_q, dl_done_d;
   logic          dl_ovf_q, dl_ovf_d;
   logic [7:0]    cpu_data_q, cpu_data_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic [AW-1:0] addr_hold_q, addr_hold_d;

   logic fifo_ne, fifo_full, rd_elig, cpu_slot;
   logic gnt_cpu, gnt_fifo, gnt_rd;
   logic push_ok, drop;

   assign fifo_ne   = (count_q != '0);
   assign fifo_full = (count_q == CW'(DEPTH));
   assign rd_elig   = rd_req & ~inflight_q;
   assign cpu_slot  = cpu_ce & cpu_sel;
   assign dl_busy   = dl_active | fifo_ne;

   assign cpu_q   = cpu_data_q;
   assign rd_q    = rd_data_q;
   assign rd_ack  = rd_ack_q;
   assign dl_done = dl_done_q;
   assign dl_ovf  = dl_ovf_q;

   // Slot decision: CPU first, then whichever background requester was not served last.
   always_comb begin
      gnt_cpu  = 1'b0;
      gnt_fifo = 1'b0;
      gnt_rd   = 1'b0;
      if (cpu_slot) begin
         gnt_cpu = 1'b1;
      end else if (fifo_ne && rd_elig) begin
         if (last_bg_q) gnt_fifo = 1'b1;
         else           gnt_rd   = 1'b1;
      end else if (fifo_ne) begin
         gnt_fifo = 1'b1;
      end else if (rd_elig) begin
         gnt_rd = 1'b1;
      end
   end

   // RAM port mux; the address holds its last value in idle cycles.
   always_comb begin
      mem_addr = addr_hold_q;
      mem_we   = 1'b0;
      mem_din  = 8'h00;
      if (gnt_cpu) begin
         mem_addr = cpu_addr;
         mem_we   = cpu_we;
         mem_din  = cpu_din;
      end else if (gnt_fifo) begin
         mem_addr = fifo_addr_q[rd_ptr_q];
         mem_we   = 1'b1;
         mem_din  = fifo_data_q[rd_ptr_q];
      end else if (gnt_rd) begin
         mem_addr = rd_addr;
      end
   end

   // Next-state for FIFO bookkeeping, read pipelines and status flags.
   always_comb begin
      push_ok     = dl_wr & (~fifo_full | gnt_fifo);
      drop        = dl_wr & fifo_full & ~gnt_fifo;
      wr_ptr_d    = push_ok  ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = gnt_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d     = count_q + CW'(push_ok) - CW'(gnt_fifo);
      last_bg_d   = last_bg_q;
      if (gnt_fifo) last_bg_d = 1'b0;
      if (gnt_rd)   last_bg_d = 1'b1;
      addr_hold_d = mem_addr;
      cpu_pend_d  = gnt_cpu & ~cpu_we;
      cpu_data_d  = cpu_pend_q ? mem_dout : cpu_data_q;
      rd_pend_d   = gnt_rd;
      rd_data_d   = rd_pend_q ? mem_dout : rd_data_q;
      rd_ack_d    = rd_pend_q;
      inflight_d  = inflight_q;
      if (rd_ack_q) inflight_d = 1'b0;
      if (gnt_rd)   inflight_d = 1'b1;
      busy_d      = dl_busy;
      dl_done_d   = busy_q & ~dl_busy;
      dl_ovf_d    = dl_ovf_q | drop;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         inflight_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         cpu_pend_q  <= 1'b0;
         last_bg_q   <= 1'b0;
         busy_q      <= 1'b0;
         rd_ack_q    <= 1'b0;
         dl_done_q   <= 1'b0;
         dl_ovf_q    <= 1'b0;
         cpu_data_q  <= 8'h00;
         rd_data_q   <= 8'h00;
         addr_hold_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         rd_pend_q   <= rd_pend_d;
         cpu_pend_q  <= cpu_pend_d;
         last_bg_q   <= last_bg_d;
         busy_q      <= busy_d;
         rd_ack_q    <= rd_ack_d;
         dl_done_q   <= dl_done_d;
         dl_ovf_q    <= dl_ovf_d;
         cpu_data_q  <= cpu_data_d;
         rd_data_q   <= rd_data_d;
         addr_hold_q <= addr_hold_d;
      end
   end

   // FIFO storage; contents are only meaningful under count_q, so no reset.
   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         fifo_addr_q[wr_ptr_q] <= dl_addr;
         fifo_data_q[wr_ptr_q] <= dl_data;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, directed stimulus, and a negedge
// monitor that checks RAM writes, reader acks and per-cycle expectations.
module tb_ram_arbiter;

   localparam int AW = 16;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          cpu_ce, cpu_sel, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din, cpu_q;
   logic          dl_active, dl_wr;
   logic [AW-1:0] dl_addr;
   logic [7:0]    dl_data;
   logic          dl_busy, dl_done, dl_ovf;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic [7:0]    rd_q;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [7:0]    mem_din;
   logic [7:0]    mem_dout = 8'h00;

   ram_arbiter #(.DEPTH(4), .AW(AW)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_ce(cpu_ce), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_q(cpu_q),
      .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
      .dl_busy(dl_busy), .dl_done(dl_done), .dl_ovf(dl_ovf),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_q(rd_q),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Behavioural RAM with preset contents at a few reader addresses.
   logic [7:0] ram [65536];
   bit         ram_wr [65536];

   function automatic logic [7:0] ram_init(input logic [AW-1:0] a);
      case (a)
         16'h0123: ram_init = 8'h5C;
         16'h0200: ram_init = 8'h77;
         16'h0201: ram_init = 8'h88;
         default:  ram_init = 8'h00;
      endcase
   endfunction

   always @(posedge clk_sys) begin
      if (mem_we === 1'b1) begin
         ram[mem_addr]    <= mem_din;
         ram_wr[mem_addr] <= 1'b1;
      end
      mem_dout <= ram_wr[mem_addr] ? ram[mem_addr] : ram_init(mem_addr);
   end

   // Scoreboard queues.
   logic [23:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   logic [39:0] exp_st [$];

   localparam logic [7:0] S_MEM_WE = 0, S_MEM_ADDR = 1, S_MEM_DIN = 2, S_CPU_Q = 3,
                          S_RD_ACK = 4, S_RD_Q = 5, S_DL_BUSY = 6, S_DL_DONE = 7,
                          S_DL_OVF = 8, S_DONE_CNT = 9, S_WRQ_LEFT = 10, S_RDQ_LEFT = 11;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   function automatic string sig_name(input logic [7:0] sel);
      case (sel)
         S_MEM_WE:   sig_name = "mem_we";
         S_MEM_ADDR: sig_name = "mem_addr";
         S_MEM_DIN:  sig_name = "mem_din";
         S_CPU_Q:    sig_name = "cpu_q";
         S_RD_ACK:   sig_name = "rd_ack";
         S_RD_Q:     sig_name = "rd_q";
         S_DL_BUSY:  sig_name = "dl_busy";
         S_DL_DONE:  sig_name = "dl_done";
         S_DL_OVF:   sig_name = "dl_ovf";
         S_DONE_CNT: sig_name = "dl_done_pulses";
         S_WRQ_LEFT: sig_name = "writes_outstanding";
         default:    sig_name = "reads_outstanding";
      endcase
   endfunction

   function automatic logic [31:0] sample(input logic [7:0] sel);
      case (sel)
         S_MEM_WE:   sample = {31'b0, mem_we};
         S_MEM_ADDR: sample = {16'b0, mem_addr};
         S_MEM_DIN:  sample = {24'b0, mem_din};
         S_CPU_Q:    sample = {24'b0, cpu_q};
         S_RD_ACK:   sample = {31'b0, rd_ack};
         S_RD_Q:     sample = {24'b0, rd_q};
         S_DL_BUSY:  sample = {31'b0, dl_busy};
         S_DL_DONE:  sample = {31'b0, dl_done};
         S_DL_OVF:   sample = {31'b0, dl_ovf};
         S_DONE_CNT: sample = done_cnt;
         S_WRQ_LEFT: sample = exp_wr.size();
         default:    sample = exp_rd.size();
      endcase
   endfunction

   // Monitor: away from the active edge, check every RAM write, every ack, and queued expectations.
   always @(negedge clk_sys) begin : mon
      logic [39:0] e;
      logic [31:0] act;
      logic [23:0] w;
      logic [7:0]  r;
      if (dl_done === 1'b1) done_cnt = done_cnt + 1;
      if (mem_we !== 1'b0) begin
         total = total + 1;
         if (exp_wr.size() == 0) begin
            bad = bad + 1;
            $display("FAIL ram_write act=%h:%h exp=none", mem_addr, mem_din);
         end else begin
            w = exp_wr.pop_front();
            if ({mem_addr, mem_din} !== w) begin
               bad = bad + 1;
               $display("FAIL ram_write act=%h:%h exp=%h:%h", mem_addr, mem_din, w[23:8], w[7:0]);
            end
         end
      end
      if (rd_ack !== 1'b0) begin
         total = total + 1;
         if (exp_rd.size() == 0) begin
            bad = bad + 1;
            $display("FAIL rd_ack act=%h exp=none", rd_q);
         end else begin
            r = exp_rd.pop_front();
            if (rd_q !== r) begin
               bad = bad + 1;
               $display("FAIL rd_data act=%h exp=%h", rd_q, r);
            end
         end
      end
      while (exp_st.size() > 0) begin
         e   = exp_st.pop_front();
         act = sample(e[39:32]);
         total = total + 1;
         if (act !== e[31:0]) begin
            bad = bad + 1;
            $display("FAIL %s act=%0h exp=%0h", sig_name(e[39:32]), act, e[31:0]);
         end
      end
   end

   task automatic exp_sig(input logic [7:0] sel, input logic [31:0] val);
      exp_st.push_back({sel, val});
   endtask

   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      reset = 1'b1;
      cpu_ce = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
      dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'h00;
      rd_req = 1'b0; rd_addr = '0;
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;

      // Idle after reset.
      exp_sig(S_CPU_Q, 0); exp_sig(S_RD_Q, 0); exp_sig(S_RD_ACK, 0);
      exp_sig(S_DL_DONE, 0); exp_sig(S_DL_OVF, 0); exp_sig(S_MEM_WE, 0);
      exp_sig(S_MEM_ADDR, 0); exp_sig(S_MEM_DIN, 0); exp_sig(S_DL_BUSY, 0);
      cyc();

      // CPU write then read of 0x3900.
      cpu_ce = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3900; cpu_din = 8'hA5;
      exp_wr.push_back({16'h3900, 8'hA5});
      exp_sig(S_MEM_WE, 1);
      cyc();
      cpu_we = 1'b0;
      exp_sig(S_MEM_WE, 0); exp_sig(S_MEM_ADDR, 32'h3900);
      cyc();
      cpu_ce = 1'b0;
      exp_sig(S_CPU_Q, 0); exp_sig(S_MEM_ADDR, 32'h3900); exp_sig(S_MEM_WE, 0);
      cyc();
      exp_sig(S_CPU_Q, 32'hA5);
      cyc();

      // Reader request to 0x0123, held through the ack cycle.
      rd_req = 1'b1; rd_addr = 16'h0123;
      exp_rd.push_back(8'h5C);
      exp_sig(S_MEM_ADDR, 32'h0123); exp_sig(S_MEM_WE, 0);
      cyc();
      exp_sig(S_RD_ACK, 0);
      cyc();
      exp_sig(S_RD_ACK, 1); exp_sig(S_RD_Q, 32'h5C);
      cyc();
      rd_req = 1'b0;
      exp_sig(S_RD_ACK, 0);
      cyc();
      exp_sig(S_RD_ACK, 0);
      cyc();

      // Five downloads while the CPU owns every slot: fifth is dropped.
      cpu_ce = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
      dl_active = 1'b1;
      for (int i = 0; i < 5; i++) begin
         dl_wr = 1'b1; dl_addr = 16'h4000 + 16'(i); dl_data = 8'h10 + 8'(i);
         if (i < 4) exp_wr.push_back({16'h4000 + 16'(i), 8'h10 + 8'(i)});
         exp_sig(S_MEM_WE, 0); exp_sig(S_DL_OVF, 0); exp_sig(S_DL_BUSY, 1);
         cyc();
      end
      dl_wr = 1'b0;
      exp_sig(S_DL_OVF, 1); exp_sig(S_MEM_WE, 0);
      cyc();
      cpu_ce = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) dl_active = 1'b0;
         exp_sig(S_MEM_WE, 1); exp_sig(S_MEM_ADDR, 32'h4000 + i);
         cyc();
      end
      exp_sig(S_DL_BUSY, 0); exp_sig(S_MEM_WE, 0); exp_sig(S_DL_DONE, 0);
      cyc();
      exp_sig(S_DL_DONE, 1);
      cyc();
      exp_sig(S_DL_DONE, 0);
      cyc();
      cyc();
      exp_sig(S_DONE_CNT, 1); exp_sig(S_DL_OVF, 1);
      cyc();

      // Fill FIFO behind the CPU, then let it contend with the reader.
      cpu_ce = 1'b1; dl_active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dl_wr = 1'b1; dl_addr = 16'h5000 + 16'(i); dl_data = 8'h20 + 8'(i);
         exp_wr.push_back({16'h5000 + 16'(i), 8'h20 + 8'(i)});
         cyc();
      end
      dl_wr = 1'b0; dl_active = 1'b0; cpu_ce = 1'b0;
      rd_req = 1'b1; rd_addr = 16'h0200;
      exp_rd.push_back(8'h77);
      exp_sig(S_MEM_ADDR, 32'h0200); exp_sig(S_MEM_WE, 0);
      cyc();
      cpu_ce = 1'b1;
      exp_sig(S_MEM_ADDR, 0); exp_sig(S_MEM_WE, 0);
      cyc();
      exp_sig(S_RD_ACK, 1); exp_sig(S_MEM_WE, 0);
      cyc();
      cpu_ce = 1'b0; rd_addr = 16'h0201;
      exp_rd.push_back(8'h88);
      exp_sig(S_MEM_WE, 1); exp_sig(S_MEM_ADDR, 32'h5000);
      cyc();
      cpu_ce = 1'b1;
      exp_sig(S_MEM_WE, 0); exp_sig(S_MEM_ADDR, 0);
      cyc();
      cpu_ce = 1'b0;
      exp_sig(S_MEM_WE, 0); exp_sig(S_MEM_ADDR, 32'h0201);
      cyc();
      exp_sig(S_MEM_WE, 1); exp_sig(S_MEM_ADDR, 32'h5001);
      cyc();
      exp_sig(S_MEM_WE, 1); exp_sig(S_MEM_ADDR, 32'h5002); exp_sig(S_RD_ACK, 1);
      cyc();
      rd_req = 1'b0;
      exp_sig(S_MEM_WE, 1); exp_sig(S_MEM_ADDR, 32'h5003); exp_sig(S_RD_ACK, 0);
      cyc();
      exp_sig(S_MEM_WE, 0); exp_sig(S_DL_BUSY, 0);
      cyc();
      cyc();

      // Reset with a reader in flight and three FIFO entries.
      cpu_ce = 1'b1; dl_active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dl_wr = 1'b1; dl_addr = 16'h6000 + 16'(i); dl_data = 8'h30 + 8'(i);
         if (i == 0) exp_sig(S_DL_OVF, 1);
         cyc();
      end
      dl_wr = 1'b0; dl_active = 1'b0; cpu_ce = 1'b0;
      rd_req = 1'b1; rd_addr = 16'h0123;
      exp_sig(S_MEM_ADDR, 32'h0123); exp_sig(S_MEM_WE, 0); exp_sig(S_DL_BUSY, 1);
      cyc();
      reset = 1'b1; cpu_ce = 1'b1; rd_req = 1'b0;
      exp_sig(S_MEM_WE, 0);
      cyc();
      reset = 1'b0; cpu_ce = 1'b0;
      exp_sig(S_RD_ACK, 0); exp_sig(S_DL_OVF, 0); exp_sig(S_DL_BUSY, 0);
      exp_sig(S_MEM_WE, 0); exp_sig(S_RD_Q, 0); exp_sig(S_MEM_ADDR, 0);
      cyc();
      exp_sig(S_RD_ACK, 0); exp_sig(S_MEM_WE, 0); exp_sig(S_DL_DONE, 0);
      exp_sig(S_WRQ_LEFT, 0); exp_sig(S_RDQ_LEFT, 0);
      @(negedge clk_sys);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
